fpu_add_arbiter: RTL and testbench



---
 rtl/fpu_types_pkg.sv | 29 ++
 rtl/float_add.sv | 88 ++++++++
 rtl/rr_arbiter.sv | 32 +++
 rtl/fpu_add_arbiter.sv | 96 +++++++++
 tb/tb_fpu_add_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_types_pkg.sv
// Shared FPU types: half-precision layout, rounding modes,
// and the request bundle used by the shared-adder arbiter.
package fpu_types_pkg;

  localparam int HALF_FLOAT_W = 16;
  localparam int HALF_EXP_W   = 5;
  localparam int HALF_MANT_W  = 10;

  localparam logic [15:0] HALF_QNAN    = 16'h7E00;
  localparam logic [14:0] HALF_MAX_FIN = 15'h7BFF;
  localparam logic [4:0]  HALF_EXP_MAX = 5'h1F;

  localparam int FPU_ADD_ARB_LATENCY = 2;

  typedef enum logic [2:0] {
    ROUND_NEAREST_EVEN    = 3'd0,
    ROUND_TOWARD_ZERO     = 3'd1,
    ROUND_DOWN            = 3'd2,
    ROUND_UP              = 3'd3,
    ROUND_NEAREST_MAX_MAG = 3'd4
  } fpu_rounding_mode_t;

  typedef struct packed {
    logic [HALF_FLOAT_W-1:0] float1;
    logic [HALF_FLOAT_W-1:0] float2;
    fpu_rounding_mode_t      rmode;
  } fpu_add_req_t;

endpackage

// File: rtl/float_add.sv
// Combinational IEEE half-precision adder with five rounding
// modes; any NaN result is the canonical quiet NaN.
module float_add
  import fpu_types_pkg::*;
(
  input  logic [HALF_FLOAT_W-1:0] i_float1,
  input  logic [HALF_FLOAT_W-1:0] i_float2,
  input  fpu_rounding_mode_t      i_rmode,
  output logic [HALF_FLOAT_W-1:0] o_sum
);

  logic        w_swap, w_sub, w_sgn;
  logic        w_nan, w_inf;
  logic [15:0] w_x, w_y;
  logic [4:0]  w_xe, w_ye;
  logic [13:0] w_xsig, w_ysig;
  logic [47:0] w_ext;
  logic [15:0] w_ya, w_m, w_n;
  logic [6:0]  w_e;
  logic [11:0] w_r;
  logic        w_g, w_st, w_inc, w_sat;

  // x always carries the larger magnitude
  assign w_swap = i_float2[14:0] > i_float1[14:0];
  assign w_x    = w_swap ? i_float2 : i_float1;
  assign w_y    = w_swap ? i_float1 : i_float2;
  assign w_sub  = w_x[15] ^ w_y[15];
  assign w_sgn  = w_x[15];

  assign w_xe   = (w_x[14:10] == 5'd0) ? 5'd1 : w_x[14:10];
  assign w_ye   = (w_y[14:10] == 5'd0) ? 5'd1 : w_y[14:10];
  assign w_xsig = {|w_x[14:10], w_x[9:0], 3'b000};
  assign w_ysig = {|w_y[14:10], w_y[9:0], 3'b000};
  assign w_ext  = {w_ysig, 34'd0} >> (w_xe - w_ye);
  assign w_ya   = {1'b0, w_ext[47:34], |w_ext[33:0]};
  assign w_m    = w_sub ? ({1'b0, w_xsig, 1'b0} - w_ya)
                        : ({1'b0, w_xsig, 1'b0} + w_ya);

  assign w_nan = (w_x[14:10] == HALF_EXP_MAX) &&
                 ((w_x[9:0] != 10'd0) ||
                  (w_sub && w_y[14:0] == {HALF_EXP_MAX, 10'd0}));
  assign w_inf = (w_x[14:10] == HALF_EXP_MAX);

  always_comb begin
    w_n = w_m;
    w_e = {2'b00, w_xe};
    if (w_m[15]) begin
      w_n = {1'b0, w_m[15:2], w_m[1] | w_m[0]};
      w_e = w_e + 7'd1;
    end else begin
      for (int i = 0; i < 14; i++) begin
        if (!w_n[14] && w_e > 7'd1) begin
          w_n = {w_n[14:0], 1'b0};
          w_e = w_e - 7'd1;
        end
      end
    end
    w_g  = w_n[3];
    w_st = |w_n[2:0];
    unique case (i_rmode)
      ROUND_TOWARD_ZERO:     w_inc = 1'b0;
      ROUND_DOWN:            w_inc = w_sgn & (w_g | w_st);
      ROUND_UP:              w_inc = ~w_sgn & (w_g | w_st);
      ROUND_NEAREST_MAX_MAG: w_inc = w_g;
      default:               w_inc = w_g & (w_st | w_n[4]);
    endcase
    w_r = {1'b0, w_n[14:4]} + {11'd0, w_inc};
    if (w_r[11]) begin
      w_r = {1'b0, w_r[11:1]};
      w_e = w_e + 7'd1;
    end
    w_sat = (i_rmode == ROUND_TOWARD_ZERO) ||
            (i_rmode == ROUND_DOWN && !w_sgn) ||
            (i_rmode == ROUND_UP && w_sgn);
    if (w_nan)
      o_sum = HALF_QNAN;
    else if (w_inf)
      o_sum = {w_sgn, HALF_EXP_MAX, 10'd0};
    else if (w_m == 16'd0)
      o_sum = {w_sub ? (i_rmode == ROUND_DOWN) : w_sgn, 15'd0};
    else if (w_e >= 7'd31)
      o_sum = w_sat ? {w_sgn, HALF_MAX_FIN}
                    : {w_sgn, HALF_EXP_MAX, 10'd0};
    else
      o_sum = {w_sgn, w_r[10] ? w_e[4:0] : 5'd0, w_r[9:0]};
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or
// after i_ptr (wrapping) wins; one-hot and encoded grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_id
);

  logic          w_found;
  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt    = '0;
    o_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = i_ptr;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[w_idx]) begin
        w_found      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_gnt_id     = w_idx;
      end
      // explicit wrap so non-power-of-2 N works
      w_idx = (w_idx == IW'(N-1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_add_arbiter.sv
// Round-robin share of one half adder among NUM_REQ lanes,
// with an OP register stage and a RES register stage.
module fpu_add_arbiter
  import fpu_types_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int FLOAT_WIDTH = HALF_FLOAT_W,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                                  CLK,
  input  logic                                  nRST,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0][FLOAT_WIDTH-1:0]   req_float1,
  input  logic [NUM_REQ-1:0][FLOAT_WIDTH-1:0]   req_float2,
  input  fpu_rounding_mode_t [NUM_REQ-1:0]      req_rmode,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic                                  flush,
  output logic                                  resp_valid,
  output logic [FLOAT_WIDTH-1:0]                resp_sum,
  output logic [ID_W-1:0]                       resp_id,
  input  logic                                  resp_ready,
  output logic                                  busy
);

  logic                   r_op_valid;
  fpu_add_req_t           r_op;
  logic [ID_W-1:0]        r_op_id;
  logic                   r_res_valid;
  logic [FLOAT_WIDTH-1:0] r_res_sum;
  logic [ID_W-1:0]        r_res_id;
  logic [ID_W-1:0]        r_ptr;

  logic                   w_res_adv, w_op_adv, w_can, w_take;
  logic [NUM_REQ-1:0]     w_gnt;
  logic [ID_W-1:0]        w_gnt_id, w_ptr_nxt;
  logic [FLOAT_WIDTH-1:0] w_sum;

  assign w_res_adv = ~r_res_valid | resp_ready;
  assign w_op_adv  = ~r_op_valid | w_res_adv;
  assign w_can     = w_op_adv & ~flush & nRST;
  assign w_take    = w_can & (|req_valid);
  assign req_ready = w_gnt & {NUM_REQ{w_can}};
  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ-1)) ? '0
                                                   : w_gnt_id + 1'b1;

  rr_arbiter #(.N(NUM_REQ), .IW(ID_W)) u_arb (
    .i_req    (req_valid),
    .i_ptr    (r_ptr),
    .o_gnt    (w_gnt),
    .o_gnt_id (w_gnt_id)
  );

  float_add u_add (
    .i_float1 (r_op.float1),
    .i_float2 (r_op.float2),
    .i_rmode  (r_op.rmode),
    .o_sum    (w_sum)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_op_valid  <= 1'b0;
      r_op        <= '0;
      r_op_id     <= '0;
      r_res_valid <= 1'b0;
      r_res_sum   <= '0;
      r_res_id    <= '0;
      r_ptr       <= '0;
    end else if (flush) begin
      r_op_valid  <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_take) begin
        r_op_valid  <= 1'b1;
        r_op.float1 <= req_float1[w_gnt_id];
        r_op.float2 <= req_float2[w_gnt_id];
        r_op.rmode  <= req_rmode[w_gnt_id];
        r_op_id     <= w_gnt_id;
        r_ptr       <= w_ptr_nxt;
      end else if (w_op_adv) begin
        r_op_valid  <= 1'b0;
      end
      if (w_res_adv) begin
        r_res_valid <= r_op_valid;
        r_res_sum   <= w_sum;
        r_res_id    <= r_op_id;
      end
    end
  end

  assign resp_valid = r_res_valid;
  assign resp_sum   = r_res_sum;
  assign resp_id    = r_res_id;
  assign busy       = r_op_valid | r_res_valid;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Randomized bench for fpu_add_arbiter against a queue-based
// model of accepts, results and the round-robin pointer.
module tb_fpu_add_arbiter;
  import fpu_types_pkg::*;

  localparam int N = 4;

  logic                      CLK = 1'b0;
  logic                      nRST = 1'b1;
  logic [N-1:0]              req_valid;
  logic [N-1:0][15:0]        req_float1;
  logic [N-1:0][15:0]        req_float2;
  fpu_rounding_mode_t [N-1:0] req_rmode;
  logic [N-1:0]              req_ready;
  logic                      flush;
  logic                      resp_valid;
  logic [15:0]               resp_sum;
  logic [1:0]                resp_id;
  logic                      resp_ready;
  logic                      busy;

  always #5 CLK = ~CLK;

  fpu_add_arbiter #(.NUM_REQ(N)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .req_valid  (req_valid),
    .req_float1 (req_float1),
    .req_float2 (req_float2),
    .req_rmode  (req_rmode),
    .req_ready  (req_ready),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  typedef struct {
    int          id;
    logic [15:0] sum;
    bit          vis;
  } ent_t;

  ent_t        q[$];
  int          m_ptr = 0;
  logic [15:0] exp_sum [N];
  int          n_checks = 0;
  int          n_errs = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] h_of(input int v);
    int m, e;
    logic [15:0] h;
    if (v == 0) return 16'h0000;
    m = (v < 0) ? -v : v;
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    h[15]    = (v < 0);
    h[14:10] = 5'(e + 15);
    h[9:0]   = 10'((e <= 10) ? (m << (10 - e)) : (m >> (e - 10)));
    return h;
  endfunction

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b,
                        input fpu_rounding_mode_t rm,
                        input logic [15:0] s);
    req_float1[i] = a;
    req_float2[i] = b;
    req_rmode[i]  = rm;
    exp_sum[i]    = s;
  endtask

  // integer operands keep every sum exact in half precision
  task automatic set_rand(input int i);
    int a, b, k;
    fpu_rounding_mode_t rm;
    logic [15:0] s;
    a  = int'($urandom_range(2048)) - 1024;
    b  = int'($urandom_range(2048)) - 1024;
    k  = int'($urandom_range(4));
    rm = fpu_rounding_mode_t'(k);
    if (a + b == 0)
      s = (a != 0 && rm == ROUND_DOWN) ? 16'h8000 : 16'h0000;
    else
      s = h_of(a + b);
    set_op(i, h_of(a), h_of(b), rm, s);
  endtask

  task automatic cycle();
    int g, idx;
    bit can, rv, hs, radv;
    logic [N-1:0] eg;
    ent_t e;
    @(negedge CLK);
    can = nRST && !flush && !(q.size() == 2 && !resp_ready);
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    eg = '0;
    if (can && g >= 0) eg[g] = 1'b1;
    rv = (q.size() > 0) && q[0].vis;
    check("req_ready", 32'(req_ready), 32'(eg));
    check("resp_valid", 32'(resp_valid), 32'(rv));
    check("busy", 32'(busy), 32'(q.size() > 0));
    if (rv) begin
      check("resp_id", 32'(resp_id), 32'(q[0].id));
      check("resp_sum", 32'(resp_sum), 32'(q[0].sum));
    end
    if (flush) begin
      q.delete();
    end else begin
      hs   = rv && resp_ready;
      radv = !rv || resp_ready;
      if (hs) void'(q.pop_front());
      if (radv)
        foreach (q[j]) q[j].vis = 1'b1;
      if (eg != '0) begin
        e.id  = g;
        e.sum = exp_sum[g];
        e.vis = 1'b0;
        q.push_back(e);
        m_ptr = (g + 1) % N;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    q.delete();
    m_ptr = 0;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    req_valid  = '0;
    flush      = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++)
      set_op(i, 16'h0, 16'h0, ROUND_NEAREST_EVEN, 16'h0);

    // reset values, with requests pending
    #1 nRST = 1'b0;
    req_valid = '1;
    #2;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_sum", 32'(resp_sum), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    @(posedge CLK);
    #1 nRST = 1'b1;

    // single 1.0 + 1.0
    set_op(0, 16'h3C00, 16'h3C00, ROUND_NEAREST_EVEN, 16'h4000);
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    repeat (3) cycle();

    // all four requesters, back-to-back grants
    do_reset();
    set_op(0, 16'h3C00, 16'h4000, ROUND_NEAREST_EVEN, 16'h4200);
    set_op(1, 16'h4000, 16'hC000, ROUND_NEAREST_EVEN, 16'h0000);
    set_op(2, 16'h7C00, 16'h3C00, ROUND_NEAREST_EVEN, 16'h7C00);
    set_op(3, 16'h7C00, 16'hFC00, ROUND_NEAREST_EVEN, 16'h7E00);
    req_valid = 4'b1111;
    repeat (5) cycle();
    req_valid = '0;
    repeat (3) cycle();

    // fill then stall the consumer
    for (int i = 0; i < N; i++) set_rand(i);
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    repeat (5) cycle();
    resp_ready = 1'b1;
    req_valid  = '0;
    repeat (3) cycle();

    // pointer wrap 3 -> 0
    req_valid = 4'b1000;
    cycle();
    req_valid = 4'b1100;
    repeat (2) cycle();
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    repeat (2) cycle();

    // flush with both stages full and req1 pending
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    repeat (2) cycle();
    req_valid = 4'b0010;
    flush     = 1'b1;
    cycle();
    flush     = 1'b0;
    req_valid = '0;
    cycle();
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    repeat (3) cycle();

    // asynchronous reset mid-stream
    #1 nRST = 1'b0;
    #1;
    check("arst_resp_valid", 32'(resp_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    #1 nRST = 1'b1;
    q.delete();
    m_ptr = 0;
    repeat (3) cycle();
    req_valid = '0;
    repeat (3) cycle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) set_rand(i);
      req_valid  = N'($urandom);
      resp_ready = ($urandom_range(9) < 7);
      flush      = ($urandom_range(31) == 0);
      cycle();
    end
    flush      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    repeat (4) cycle();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
